// File: rtl/irq_seq_pkg.sv
// Shared types and helpers for the interrupt dispatch sequencer.
package irq_seq_pkg;

  // One state per M-cycle of the five-step dispatch, plus the resting state.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWait  = 3'd1,
    StDecSp = 3'd2,
    StPushH = 3'd3,
    StPushL = 3'd4,
    StJump  = 3'd5
  } irq_state_e;

  localparam logic [7:0] VecBaseDefault   = 8'h40;
  localparam logic [7:0] VecStrideDefault = 8'd8;

  // Low byte of the vector for interrupt line n; the high byte is always 0.
  function automatic logic [7:0] vec_of(input logic [7:0] n,
                                        input logic [7:0] base,
                                        input logic [7:0] stride);
    logic [7:0] off;
    off = n * stride;
    return base + off;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-set-bit priority encoder: bit 0 has the highest priority.
module irq_prio_enc #(
  parameter int unsigned Width = 8,
  parameter int unsigned IdxW  = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] req_i,
  output logic [Width-1:0] onehot_o,
  output logic [IdxW-1:0]  idx_o,
  output logic             any_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    for (int i = int'(Width) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        idx_o       = IdxW'(i);
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_dispatch_seq.sv
// Interrupt entry sequencer: qualifies IE & IF, gates on IME (with EI delay),
// wakes HALT, and walks the five-step dispatch that pushes PC and loads the vector.
module irq_dispatch_seq
  import irq_seq_pkg::*;
#(
  parameter int unsigned NUM_IRQ    = 8,
  parameter logic [7:0]  VEC_BASE   = VecBaseDefault,
  parameter logic [7:0]  VEC_STRIDE = VecStrideDefault
) (
  input  logic               CLK,
  input  logic               SYNC_RES,
  input  logic               step,
  input  logic               instr_end,
  input  logic               ei_op,
  input  logic               di_op,
  input  logic               reti_op,
  input  logic               halt,
  input  logic [NUM_IRQ-1:0] ie,
  input  logic [NUM_IRQ-1:0] irq_if,
  output logic               ime,
  output logic               busy,
  output logic               wake,
  output logic               sp_dec,
  output logic               sp_to_addr,
  output logic               pch_to_dl,
  output logic               pcl_to_dl,
  output logic               pc_load_vec,
  output logic [7:0]         vector,
  output logic [NUM_IRQ-1:0] irq_ack
);

  localparam int unsigned IdxW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] pend_onehot;
  logic [IdxW-1:0]    pend_idx;
  logic               pend_any;

  irq_state_e         state_q, state_d;
  logic               ime_q, ime_d;
  logic               ei_pend_q, ei_pend_d;
  logic [7:0]         vector_q, vector_d;
  logic [NUM_IRQ-1:0] irq_ack_q, irq_ack_d;
  logic               ime_eff;
  logic               take;

  assign pend = ie & irq_if;
  assign wake = |pend;

  irq_prio_enc #(
    .Width (NUM_IRQ),
    .IdxW  (IdxW)
  ) u_prio_enc (
    .req_i    (pend),
    .onehot_o (pend_onehot),
    .idx_o    (pend_idx),
    .any_o    (pend_any)
  );

  // IME as seen at this boundary: RETI enables at once, a pending EI matures at the
  // next instruction end, and DI suppresses both.
  always_comb begin
    ime_eff = ~di_op & (ime_q | reti_op | (ei_pend_q & instr_end));
    take    = ime_eff & pend_any & (instr_end | halt);
  end

  // Next-state, IME bookkeeping and the PUSH_L re-sample of pending requests.
  always_comb begin
    state_d   = state_q;
    ime_d     = ime_q;
    ei_pend_d = ei_pend_q;
    vector_d  = vector_q;
    irq_ack_d = '0;
    if (step) begin
      case (state_q)
        StIdle: begin
          if (take) begin
            state_d   = StWait;
            ime_d     = 1'b0;
            ei_pend_d = 1'b0;
          end else if (di_op) begin
            ime_d     = 1'b0;
            ei_pend_d = 1'b0;
          end else begin
            if (reti_op || (ei_pend_q && instr_end)) begin
              ime_d = 1'b1;
            end
            ei_pend_d = ei_op | (ei_pend_q & ~instr_end);
          end
        end
        StWait:  state_d = StDecSp;
        StDecSp: state_d = StPushH;
        StPushH: state_d = StPushL;
        StPushL: begin
          state_d = StJump;
          // The PCH push may have overwritten IE, so the winner is chosen only now.
          if (pend_any) begin
            vector_d  = vec_of(8'(pend_idx), VEC_BASE, VEC_STRIDE);
            irq_ack_d = pend_onehot;
          end else begin
            vector_d  = 8'h00;
          end
        end
        StJump:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (SYNC_RES) begin
      state_q   <= StIdle;
      ime_q     <= 1'b0;
      ei_pend_q <= 1'b0;
      vector_q  <= 8'h00;
      irq_ack_q <= '0;
    end else begin
      state_q   <= state_d;
      ime_q     <= ime_d;
      ei_pend_q <= ei_pend_d;
      vector_q  <= vector_d;
      irq_ack_q <= irq_ack_d;
    end
  end

  // Bus strobes are a pure decode of the registered state, so they hold between steps.
  always_comb begin
    busy        = (state_q != StIdle);
    sp_dec      = (state_q == StDecSp) || (state_q == StPushH);
    sp_to_addr  = (state_q == StPushH) || (state_q == StPushL);
    pch_to_dl   = (state_q == StPushH);
    pcl_to_dl   = (state_q == StPushL);
    pc_load_vec = (state_q == StJump);
    ime         = ime_q;
    vector      = vector_q;
    irq_ack     = irq_ack_q;
  end

endmodule

// File: tb/tb_irq_dispatch_seq.sv
// Scoreboard bench for irq_dispatch_seq: stimulus pushes the expected ack/vector of each
// dispatch; a monitor pops and compares on the first clock of every JUMP step.
module tb_irq_dispatch_seq;

  logic       clk = 1'b0;
  logic       sync_res;
  logic       step, instr_end, ei_op, di_op, reti_op, halt;
  logic [7:0] ie, irq_if;
  logic       ime, busy, wake, sp_dec, sp_to_addr, pch_to_dl, pcl_to_dl, pc_load_vec;
  logic [7:0] vector, irq_ack;
  logic [5:0] pat;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] ack;
    logic [7:0] vec;
  } exp_t;
  exp_t exp_q[$];

  // {busy, sp_dec, sp_to_addr, pch_to_dl, pcl_to_dl, pc_load_vec} for WAIT..JUMP, IDLE
  logic [5:0] seq_pat [6] = '{6'b100000, 6'b110000, 6'b111100, 6'b101010, 6'b100001,
                              6'b000000};

  always #5 clk = ~clk;

  assign pat = {busy, sp_dec, sp_to_addr, pch_to_dl, pcl_to_dl, pc_load_vec};

  irq_dispatch_seq dut (
    .CLK         (clk),
    .SYNC_RES    (sync_res),
    .step        (step),
    .instr_end   (instr_end),
    .ei_op       (ei_op),
    .di_op       (di_op),
    .reti_op     (reti_op),
    .halt        (halt),
    .ie          (ie),
    .irq_if      (irq_if),
    .ime         (ime),
    .busy        (busy),
    .wake        (wake),
    .sp_dec      (sp_dec),
    .sp_to_addr  (sp_to_addr),
    .pch_to_dl   (pch_to_dl),
    .pcl_to_dl   (pcl_to_dl),
    .pc_load_vec (pc_load_vec),
    .vector      (vector),
    .irq_ack     (irq_ack)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    instr_end = 1'b0;
    ei_op     = 1'b0;
    di_op     = 1'b0;
    reti_op   = 1'b0;
    halt      = 1'b0;
  endtask

  // RETI boundary with nothing pending: sets IME without dispatching.
  task automatic set_ime();
    ie        = 8'h00;
    irq_if    = 8'h00;
    reti_op   = 1'b1;
    instr_end = 1'b1;
    cyc(1);
    quiet();
    chk("ime_set", ime, 1);
  endtask

  // Called right after the take edge; runs WAIT..JUMP and lands in IDLE.
  task automatic finish_dispatch(input string name);
    chk({name, "_busy_start"}, busy, 1);
    chk({name, "_ime_clr"}, ime, 0);
    quiet();
    cyc(5);
    chk({name, "_busy_end"}, busy, 0);
  endtask

  // Monitor: compare ack/vector on the first clock of JUMP, otherwise ack must be 0.
  initial begin
    logic prev_plv;
    exp_t e;
    prev_plv = 1'b0;
    forever begin
      @(negedge clk);
      if (!sync_res) begin
        if (pc_load_vec && !prev_plv) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_dispatch: got ack %h vector %h expected none",
                     irq_ack, vector);
          end else begin
            e = exp_q.pop_front();
            chk("ack", irq_ack, e.ack);
            chk("vector", vector, e.vec);
          end
        end else begin
          chk("no_ack", irq_ack, 0);
        end
      end
      prev_plv = pc_load_vec;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    sync_res = 1'b1;
    step     = 1'b1;
    ie       = 8'h00;
    irq_if   = 8'h00;
    quiet();
    cyc(2);
    sync_res = 1'b0;
    chk("rst_strobes", pat, 6'b000000);
    chk("rst_ime", ime, 0);
    chk("rst_vector", vector, 8'h00);
    chk("rst_ack", irq_ack, 0);
    chk("rst_wake", wake, 0);

    // Basic dispatch, strobe pattern per step.
    set_ime();
    ie = 8'h01; irq_if = 8'h01; instr_end = 1'b1;
    exp_q.push_back('{ack: 8'h01, vec: 8'h40});
    cyc(1);
    quiet();
    chk("d1_ime", ime, 0);
    chk("d1_pat0", pat, seq_pat[0]);
    for (int i = 1; i < 6; i++) begin
      cyc(1);
      chk($sformatf("d1_pat%0d", i), pat, seq_pat[i]);
    end
    irq_if = 8'h00;

    // Priority: 0x14 -> bit 2, taken at the RETI boundary itself.
    ie = 8'h1F; irq_if = 8'h14; reti_op = 1'b1; instr_end = 1'b1;
    exp_q.push_back('{ack: 8'h04, vec: 8'h50});
    cyc(1);
    finish_dispatch("prio2");
    irq_if = 8'h10;
    chk("prio_wake", wake, 1);
    instr_end = 1'b1;
    cyc(1);
    chk("no_dispatch_ime0", busy, 0);
    reti_op = 1'b1;
    exp_q.push_back('{ack: 8'h10, vec: 8'h60});
    cyc(1);
    finish_dispatch("prio4");
    irq_if = 8'h00;

    // EI delay: not taken at the EI boundary, taken at the next one.
    ie = 8'h01; irq_if = 8'h01; ei_op = 1'b1; instr_end = 1'b1;
    cyc(1);
    chk("ei_no_take", busy, 0);
    chk("ei_ime_late", ime, 0);
    ei_op = 1'b0;
    exp_q.push_back('{ack: 8'h01, vec: 8'h40});
    cyc(1);
    finish_dispatch("ei");

    // EI then DI: never dispatches.
    ei_op = 1'b1; instr_end = 1'b1;
    cyc(1);
    ei_op = 1'b0; di_op = 1'b1;
    cyc(1);
    di_op = 1'b0;
    chk("eidi_busy", busy, 0);
    cyc(3);
    chk("eidi_busy_later", busy, 0);
    chk("eidi_ime", ime, 0);
    quiet();
    irq_if = 8'h00;

    // IE cleared before the PUSH_L re-sample: cancelled dispatch to 0x0000.
    ie = 8'h01; irq_if = 8'h01; reti_op = 1'b1; instr_end = 1'b1;
    exp_q.push_back('{ack: 8'h00, vec: 8'h00});
    cyc(1);
    quiet();
    cyc(2);
    chk("cancel_pushh", pch_to_dl, 1);
    ie = 8'h00;
    cyc(2);
    chk("cancel_jump", pc_load_vec, 1);
    chk("cancel_vec", vector, 8'h00);
    cyc(1);
    irq_if = 8'h00;

    // HALT wake with IME off, then HALT entry without instr_end.
    halt = 1'b1; ie = 8'h02; irq_if = 8'h02;
    #1;
    chk("halt_wake", wake, 1);
    cyc(3);
    chk("halt_ime0_busy", busy, 0);
    quiet();
    set_ime();
    halt = 1'b1; ie = 8'h02; irq_if = 8'h02;
    exp_q.push_back('{ack: 8'h02, vec: 8'h48});
    cyc(1);
    finish_dispatch("halt");
    irq_if = 8'h00;

    // step = 0 freezes WAIT and JUMP; ack stays one clock wide.
    set_ime();
    ie = 8'h01; irq_if = 8'h01; instr_end = 1'b1;
    exp_q.push_back('{ack: 8'h01, vec: 8'h40});
    cyc(1);
    quiet();
    step = 1'b0;
    cyc(3);
    chk("frz_wait", pat, seq_pat[0]);
    step = 1'b1;
    cyc(4);
    step = 1'b0;
    cyc(1);
    chk("frz_jump", pat, seq_pat[4]);
    chk("frz_ack_1clk", irq_ack, 0);
    chk("frz_vec", vector, 8'h40);
    cyc(1);
    step = 1'b1;
    cyc(1);
    chk("frz_idle", pat, seq_pat[5]);
    irq_if = 8'h00;

    // Reset during PUSH_H aborts with no ack.
    set_ime();
    ie = 8'h01; irq_if = 8'h01; instr_end = 1'b1;
    cyc(1);
    quiet();
    cyc(2);
    chk("abort_pushh", pat, seq_pat[2]);
    sync_res = 1'b1;
    cyc(1);
    sync_res = 1'b0;
    chk("abort_pat", pat, 6'b000000);
    chk("abort_ime", ime, 0);
    chk("abort_ack", irq_ack, 0);
    cyc(3);
    chk("abort_stays_idle", busy, 0);
    ie = 8'h00; irq_if = 8'h00;

    cyc(2);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_dispatch_seq.md
Name: irq_dispatch_seq

Overview:
- Sequences interrupt entry for the bottom datapath: IF/IE qualification, IME gating, EI delay, HALT wake, five-step dispatch.
- Dispatch steps: idle step, SP decrement, push PCH, push PCL, load PC with vector.
- Drives the SP/PC/IncDec bus-select strobes and the one-hot IRQ acknowledge.
- Sits beside the register/IRQ logic; advances one step per M-cycle, qualified by `step`.

Parameters:
- NUM_IRQ, 8, number of interrupt lines; bit 0 has the highest priority.
- VEC_BASE, 8'h40, vector of IRQ 0.
- VEC_STRIDE, 8, vector spacing; vector = VEC_BASE + n*VEC_STRIDE (PCH = 0).

Ports:
- CLK  in  1  single core clock.
- SYNC_RES  in  1  synchronous active-high reset.
- step  in  1  M-cycle boundary; the FSM and IME logic advance only when it is 1.
- instr_end  in  1  the current instruction completes this M-cycle (dispatch sample point).
- ei_op  in  1  EI executing (qualified with step).
- di_op  in  1  DI executing (qualified with step).
- reti_op  in  1  RETI executing (qualified with step).
- halt  in  1  core is in HALT.
- ie  in  NUM_IRQ  IE register contents.
- irq_if  in  NUM_IRQ  IF register contents.
- ime  out  1  interrupt master enable.
- busy  out  1  dispatch in progress; inhibits opcode fetch.
- wake  out  1  combinational: (ie & irq_if) != 0; exits HALT regardless of IME.
- sp_dec  out  1  request SP decrement via IncDec (TTB3 path).
- sp_to_addr  out  1  drive SP onto the address bus.
- pch_to_dl  out  1  PCH onto DL, with write strobe.
- pcl_to_dl  out  1  PCL onto DL, with write strobe.
- pc_load_vec  out  1  load PC from vector.
- vector  out  8  PCL vector value.
- irq_ack  out  NUM_IRQ  one-hot IF clear, 1 cycle wide.

Behaviour:
- Reset (synchronous, wins over everything):
  - state = IDLE, ime = 0, ei_pend = 0.
  - All strobes, irq_ack and busy = 0; vector = 8'h00.
- pend = ie & irq_if. All registered outputs change only on a CLK edge where step = 1. Between steps, strobes hold their value; irq_ack is high for exactly one clock.
- States, each lasting one step:
  - IDLE: if ime & |pend & (instr_end | halt), go to WAIT, set busy = 1 and clear ime on the same edge.
  - WAIT: no bus activity; PC is not incremented.
  - DEC_SP: sp_dec = 1.
  - PUSH_H: sp_to_addr, pch_to_dl and sp_dec = 1.
  - PUSH_L: sp_to_addr and pcl_to_dl = 1. At the end of this step, pend is re-sampled (the PCH write may have hit IE at 0xFFFF):
    - Lowest set bit n: vector = VEC_BASE + n*VEC_STRIDE, irq_ack[n] = 1.
    - pend = 0: vector = 8'h00, no ack (cancelled dispatch jumps to 0x0000).
  - JUMP: pc_load_vec = 1; busy drops on exit; return to IDLE.
- Total dispatch is 5 steps, fixed latency. Entry from HALT adds no extra step.
- IME rules:
  - DI: ime = 0 and ei_pend = 0 immediately.
  - EI: ei_pend = 1; ime becomes 1 at the next instr_end & step after the EI instruction, so an interrupt is never taken on the EI boundary itself.
  - EI followed by DI before ime sets: ime stays 0.
  - RETI: ime = 1 immediately; dispatch is possible at the RETI boundary.
  - ei_op/di_op/reti_op are ignored while busy.
- Simultaneous requests: strict priority, bit 0 wins; only one ack per dispatch. Other IF bits stay set and dispatch on a later boundary once ime is restored.
- New requests during a dispatch are ignored until IDLE, except the PUSH_L re-sample.
- step = 0 freezes the FSM and holds all outputs (wake excepted).
- SYNC_RES mid-dispatch aborts to IDLE with no ack; PC/SP side effects already committed are not undone.
- Vector arithmetic is 8-bit with no overflow for NUM_IRQ <= 8 (max 8'h78).

Decomposition:
- Package irq_seq_pkg:
  - state enum {IDLE, WAIT, DEC_SP, PUSH_H, PUSH_L, JUMP}.
  - VEC_BASE/VEC_STRIDE defaults.
  - Function vec_of(n).
- Sub-module irq_prio_enc: combinational lowest-set-bit encoder; outputs one-hot, index and any.

Test Plan:
- ime=1, ie=8'h01, irq_if=8'h01, instr_end & step -> states WAIT..JUMP over 5 steps; irq_ack=8'h01 at PUSH_L; vector=8'h40; ime=0.
- ie=8'h1F, irq_if=8'h14 -> irq_ack=8'h04, vector=8'h50; bit 4 remains pending, taken after RETI with vector 8'h60.
- EI at boundary k with pend set -> no dispatch at k; dispatch starts at boundary k+1. EI then DI -> never dispatches.
- IE cleared (ie=0) between PUSH_H and the PUSH_L sample -> irq_ack=0, vector=8'h00, pc_load_vec still pulses.
- halt=1, ime=0, pend=8'h02 -> wake=1, no dispatch. Same with ime=1 -> dispatch without instr_end, vector=8'h48.
- SYNC_RES asserted during PUSH_H -> next clock: state IDLE, busy=0, all strobes 0, ime=0, no ack.
